// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder feeding instruction memory through an in-order word FIFO
// Illegal requests are consumed without a push and latch the sticky err flag.
module instr_encoder #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_kind,
    input  logic [2:0]            in_funct3,
    input  logic                  in_alt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  err,
    output logic [15:0]           words_written
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]          FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]   BASE     = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [3:0] K_R      = 4'd0;
    localparam logic [3:0] K_IALU   = 4'd1;
    localparam logic [3:0] K_SHIFT  = 4'd2;
    localparam logic [3:0] K_LOAD   = 4'd3;
    localparam logic [3:0] K_STORE  = 4'd4;
    localparam logic [3:0] K_BRANCH = 4'd5;
    localparam logic [3:0] K_JAL    = 4'd6;
    localparam logic [3:0] K_JALR   = 4'd7;
    localparam logic [3:0] K_LUI    = 4'd8;
    localparam logic [3:0] K_AUIPC  = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           words_q, words_d;
    logic                  err_q, err_d;

    logic                  fits12, fits13, fits21, shamt_ok, upper_ok;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] enc_word;
    logic                  enc_legal;
    logic                  accept, push, pop;

    // Range checks compare the immediate against its own sign-extension from the field width.
    assign fits12   = (in_imm == {{(DATA_WIDTH-12){in_imm[11]}}, in_imm[11:0]});
    assign fits13   = (in_imm == {{(DATA_WIDTH-13){in_imm[12]}}, in_imm[12:0]});
    assign fits21   = (in_imm == {{(DATA_WIDTH-21){in_imm[20]}}, in_imm[20:0]});
    assign shamt_ok = (in_imm[DATA_WIDTH-1:5] == '0);
    assign upper_ok = (in_imm[11:0] == 12'd0);

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        funct7    = 7'h00;
        case (in_kind)
            K_R: begin
                if (in_alt && (in_funct3 == 3'b000 || in_funct3 == 3'b101)) begin
                    funct7 = 7'h20;
                end
                enc_legal = 1'b1;
                enc_word  = {funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            end
            K_IALU: begin
                enc_legal = fits12;
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
            end
            K_SHIFT: begin
                if (in_alt) begin
                    funct7 = 7'h20;
                end
                enc_legal = shamt_ok &&
                            (in_funct3 == 3'b101 || (in_funct3 == 3'b001 && !in_alt));
                enc_word  = {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
            end
            K_LOAD: begin
                enc_legal = fits12 && (in_funct3 != 3'b011) &&
                            (in_funct3 != 3'b110) && (in_funct3 != 3'b111);
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            end
            K_STORE: begin
                enc_legal = fits12 && (in_funct3 <= 3'b010);
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            end
            K_BRANCH: begin
                enc_legal = fits13 && !in_imm[0] &&
                            (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            K_JAL: begin
                enc_legal = fits21 && !in_imm[0];
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            end
            K_JALR: begin
                enc_legal = fits12;
                enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            end
            K_LUI: begin
                enc_legal = upper_ok;
                enc_word  = {in_imm[31:12], in_rd, OP_LUI};
            end
            K_AUIPC: begin
                enc_legal = upper_ok;
                enc_word  = {in_imm[31:12], in_rd, OP_AUIPC};
            end
            default: begin
                enc_legal = 1'b0;
                enc_word  = '0;
            end
        endcase
    end

    // No bypass: a full FIFO refuses input even when the head is leaving this cycle.
    assign in_ready      = (count_q != FULL_CNT) && !rst;
    assign wr_valid      = (count_q != '0) && !rst;
    assign wr_data       = mem_q[rd_ptr_q];
    assign wr_addr       = addr_q;
    assign err           = err_q;
    assign words_written = words_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = wr_valid && wr_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        addr_d  = pop ? addr_q + ADDR_WIDTH'(4) : addr_q;
        words_d = (pop && words_q != 16'hFFFF) ? words_q + 16'd1 : words_q;
        err_d   = err_q || (accept && !enc_legal);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE;
            words_q  <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed bench for instr_encoder with a queue-based reference model
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_alt, wr_ready;
    logic [3:0]  in_kind;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_ready, wr_valid, err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] words_written;
    logic        w_in_ready, w_wr_valid, w_err;
    logic [7:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [15:0] w_words;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .err(err), .words_written(words_written)
    );

    instr_encoder #(.BASE_ADDR(32'hF8)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .wr_valid(w_wr_valid), .wr_ready(wr_ready), .wr_addr(w_wr_addr),
        .wr_data(w_wr_data), .err(w_err), .words_written(w_words)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];
    int          exp_addr = 0;
    int          exp_cnt  = 0;
    bit          exp_err  = 0;
    bit          cur_legal;
    logic [31:0] cur_word;
    bit          rand_rdy = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fld(input logic [31:0] x, input int lo, input int n);
        return (x >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Reference encoder: fields placed by shifting into their bit positions, legality by integer ranges.
    function automatic void model(input int k, input int f3, input int alt, input int rd,
                                  input int rs1, input int rs2, input logic [31:0] imm,
                                  output bit legal, output logic [31:0] w);
        int s;
        bit in12;
        s    = $signed(imm);
        in12 = (s >= -2048) && (s <= 2047);
        legal = 0;
        w     = 0;
        case (k)
            0: begin legal = 1;
               w = (((alt != 0) && (f3 == 0 || f3 == 5)) ? 32'h20 : 32'h0) << 25 |
                   rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h33; end
            1: begin legal = in12;
               w = fld(imm, 0, 12) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h13; end
            2: begin legal = (f3 == 5 || (f3 == 1 && alt == 0)) && (imm < 32);
               w = ((alt != 0) ? 32'h20 : 32'h0) << 25 | fld(imm, 0, 5) << 20 |
                   rs1 << 15 | f3 << 12 | rd << 7 | 32'h13; end
            3: begin legal = in12 && f3 != 3 && f3 < 6;
               w = fld(imm, 0, 12) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h03; end
            4: begin legal = in12 && f3 <= 2;
               w = fld(imm, 5, 7) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 |
                   fld(imm, 0, 5) << 7 | 32'h23; end
            5: begin legal = s >= -4096 && s <= 4095 && imm[0] == 0 && f3 != 2 && f3 != 3;
               w = fld(imm, 12, 1) << 31 | fld(imm, 5, 6) << 25 | rs2 << 20 | rs1 << 15 |
                   f3 << 12 | fld(imm, 1, 4) << 8 | fld(imm, 11, 1) << 7 | 32'h63; end
            6: begin legal = s >= -(1 << 20) && s <= (1 << 20) - 1 && imm[0] == 0;
               w = fld(imm, 20, 1) << 31 | fld(imm, 1, 10) << 21 | fld(imm, 11, 1) << 20 |
                   fld(imm, 12, 8) << 12 | rd << 7 | 32'h6F; end
            7: begin legal = in12;
               w = fld(imm, 0, 12) << 20 | rs1 << 15 | rd << 7 | 32'h67; end
            8, 9: begin legal = fld(imm, 0, 12) == 0;
               w = (imm & 32'hFFFFF000) | rd << 7 | ((k == 8) ? 32'h37 : 32'h17); end
            default: legal = 0;
        endcase
    endfunction

    // Scoreboard: compare the state left by the previous edge, then apply the transfers of the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_wr_valid", wr_valid, 0);
            exp_q.delete();
            exp_addr = 0;
            exp_cnt  = 0;
            exp_err  = 0;
        end else begin
            check("wr_valid", wr_valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_q.size() < 4);
            check("err", err, exp_err);
            check("words_written", words_written, exp_cnt);
            check("wr_addr", wr_addr, exp_addr);
            check("wrap_addr", w_wr_addr, (exp_addr + 248) % 256);
            check("wrap_words", w_words, exp_cnt);
            if (exp_q.size() != 0) begin
                check("wr_data", wr_data, exp_q[0]);
                check("wrap_data", w_wr_data, exp_q[0]);
            end
            if (in_valid && in_ready) begin
                if (cur_legal) exp_q.push_back(cur_word);
                else exp_err = 1;
            end
            if (wr_valid && wr_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_addr = (exp_addr + 4) % 256;
                if (exp_cnt < 65535) exp_cnt++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input int k, input int f3, input int alt, input int rd, input int rs1,
                         input int rs2, input logic [31:0] imm, input bit legal, input logic [31:0] w);
        bit accepted;
        in_kind = k[3:0]; in_funct3 = f3[2:0]; in_alt = alt[0];
        in_rd = rd[4:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0]; in_imm = imm;
        cur_legal = legal;
        cur_word  = w;
        in_valid  = 1;
        accepted  = 0;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!accepted) check("accept_timeout", 0, 1);
    endtask

    task automatic send(input int k, input int f3, input int alt, input int rd, input int rs1,
                        input int rs2, input logic [31:0] imm);
        bit          legal;
        logic [31:0] w;
        model(k, f3, alt, rd, rs1, rs2, imm, legal, w);
        drive(k, f3, alt, rd, rs1, rs2, imm, legal, w);
    endtask

    task automatic send_rand();
        int          k;
        logic [31:0] imm;
        k = $urandom_range(0, 11);
        if ($urandom_range(0, 9) == 0) imm = $urandom;
        else case (k)
            2:       imm = $urandom_range(0, 31);
            5:       imm = ($urandom_range(0, 8191) - 4096) & ~32'd1;
            6:       imm = ($urandom_range(0, 2097151) - 1048576) & ~32'd1;
            8, 9:    imm = $urandom & 32'hFFFFF000;
            default: imm = $urandom_range(0, 4095) - 2048;
        endcase
        send(k, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), imm);
    endtask

    task automatic pulse_reset();
        rst = 1;
        cycles(1);
        rst = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) wr_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; wr_ready = 0; in_kind = 0; in_funct3 = 0; in_alt = 0;
        in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; cur_legal = 0; cur_word = 0;
        cycles(3);
        rst = 0;
        cycles(1);
        check("reset_addr", wr_addr, 8'h00);
        check("reset_wrap_addr", w_wr_addr, 8'hF8);
        check("reset_in_ready", in_ready, 1);

        wr_ready = 1;
        drive(1, 0, 0, 1, 0, 0, 32'd5, 1, 32'h00500093);
        drive(0, 0, 1, 3, 1, 2, 32'd0, 1, 32'h402081B3);
        drive(4, 2, 0, 0, 1, 2, 32'd8, 1, 32'h0020A423);
        drive(5, 0, 0, 0, 1, 2, -32'sd4, 1, 32'hFE208EE3);
        drive(6, 0, 0, 1, 0, 0, 32'd8, 1, 32'h008000EF);
        drive(8, 0, 0, 5, 0, 0, 32'h12345000, 1, 32'h123452B7);
        cycles(4);
        check("basic_words", words_written, 6);

        drive(1, 0, 0, 1, 0, 0, 32'h800, 0, 32'h0);
        cycles(2);
        check("illegal_addi_err", err, 1);
        check("illegal_addi_valid", wr_valid, 0);
        drive(5, 0, 0, 0, 1, 2, 32'd3, 0, 32'h0);
        cycles(3);
        check("illegal_err_sticky", err, 1);
        pulse_reset();
        cycles(1);
        check("err_cleared", err, 0);

        wr_ready = 0;
        for (int i = 0; i < 4; i++) send(1, 0, 0, i + 1, 0, 0, i * 16);
        in_kind = 1; in_funct3 = 0; in_imm = 32'd100; in_valid = 1;
        cur_legal = 0;
        cycles(3);
        check("bp_in_ready", in_ready, 0);
        check("bp_wr_valid", wr_valid, 1);
        check("bp_words", words_written, 0);
        in_valid = 0;
        wr_ready = 1;
        send(1, 0, 0, 9, 0, 0, 32'd100);
        cycles(8);
        check("bp_drained", words_written, 5);

        wr_ready = 0;
        for (int i = 0; i < 3; i++) send(9, 0, 0, i, 0, 0, (i + 1) << 12);
        cycles(1);
        wr_ready = 1;
        pulse_reset();
        wr_ready = 0;
        check("midrst_valid", wr_valid, 0);
        check("midrst_addr", wr_addr, 8'h00);
        check("midrst_words", words_written, 0);

        wr_ready = 1;
        for (int i = 0; i < 3; i++) send(7, 0, 0, i, i, 0, i);
        cycles(3);
        check("wrap_final_addr", w_wr_addr, 8'h04);
        check("wrap_final_words", w_words, 3);

        for (int b = 0; b < 3; b++) begin
            pulse_reset();
            rand_rdy = 1;
            for (int i = 0; i < 120; i++) begin
                send_rand();
                if ($urandom_range(0, 3) == 0) cycles(1);
            end
            rand_rdy = 0;
            wr_ready = 1;
            cycles(8);
            check("burst_drained", wr_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, which sets the instruction and immediate width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, which sets the instruction-memory byte-address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, which sets the first write address after reset.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, which sets the number of encoded-word buffer entries (power of 2).
REQ-005 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: an encode request is present.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-009 SHALL have port in_kind, input, 4 bits, with codes 0 R, 1 I-ALU, 2 I-shift, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC; codes 10-15 are illegal.
REQ-010 SHALL have port in_funct3, input, 3 bits: the funct3 field.
REQ-011 SHALL have port in_alt, input, 1 bit: selects funct7=0x20 (sub/sra/srai).
REQ-012 SHALL have ports in_rd, in_rs1 and in_rs2, each input, 5 bits: register indices.
REQ-013 SHALL have port in_imm, input, DATA_WIDTH bits: the signed byte-offset or value immediate.
REQ-014 SHALL have port wr_valid, output, 1 bit: an encoded word is presented to instruction memory.
REQ-015 SHALL have port wr_ready, input, 1 bit: memory accepts the word.
REQ-016 SHALL have port wr_addr, output, ADDR_WIDTH bits: the byte address of the presented word.
REQ-017 SHALL have port wr_data, output, DATA_WIDTH bits: the encoded RV32I instruction.
REQ-018 SHALL have port err, output, 1 bit: sticky flag set by an illegal request.
REQ-019 SHALL have port words_written, output, 16 bits: count of completed memory writes.

Function
REQ-020 An input transfer SHALL occur only when in_valid and in_ready are both high at a rising edge.
REQ-021 in_ready SHALL equal "FIFO not full and rst low"; there is no bypass while full, even when a pop occurs in the same cycle.
REQ-022 An accepted legal request SHALL be encoded and pushed into the FIFO at that edge; wr_valid SHALL be high no earlier than the next cycle (latency 1).
REQ-023 Encoding, R: {funct7, rs2, rs1, f3, rd, 0110011}; funct7 = 0x20 only when in_alt is set and f3 is 000 or 101, otherwise 0x00.
REQ-024 Encoding, I-ALU, LOAD (0000011) and JALR (1100111, f3 forced to 000): {imm[11:0], rs1, f3, rd, opcode}; I-ALU opcode is 0010011.
REQ-025 Encoding, I-shift: {in_alt?0100000:0000000, imm[4:0], rs1, f3, rd, 0010011}; f3 must be 001 or 101; in_alt with 001 is illegal.
REQ-026 Encoding, STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}; f3 must be 000, 001 or 010.
REQ-027 Encoding, BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}; f3 of 010 or 011 is illegal.
REQ-028 Encoding, JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
REQ-029 Encoding, LUI (0110111) and AUIPC (0010111): {imm[31:12], rd, opcode}.
REQ-030 The following immediates SHALL be illegal:
- I, LOAD, STORE, JALR: imm not equal to the sign-extension of imm[11:0].
- BRANCH: imm outside the 13-bit signed range, or imm[0]=1.
- JAL: imm outside the 21-bit signed range, or imm[0]=1.
- Shift: imm[31:5] != 0.
- LUI/AUIPC: imm[11:0] != 0.
- LOAD: f3 values 011, 110 and 111.
REQ-031 An illegal request SHALL still be accepted (handshake completes), SHALL NOT be pushed, and SHALL set err to 1 at that edge; err stays 1 until rst.
REQ-032 wr_valid SHALL equal "FIFO not empty"; wr_data SHALL be the FIFO head word.
REQ-033 wr_data and wr_addr SHALL be held stable while wr_valid=1 and wr_ready=0.
REQ-034 On wr_valid and wr_ready: pop the head, then wr_addr += 4 modulo 2^ADDR_WIDTH (wraps to 0, not to BASE_ADDR), then words_written += 1 (saturates at 0xFFFF).
REQ-035 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve order; the FIFO SHALL be strictly in order.

Reset
REQ-036 While rst=1 at an edge: FIFO emptied, wr_valid=0, in_ready=0, wr_addr=BASE_ADDR, words_written=0, err=0.
REQ-037 rst asserted mid-stream SHALL discard buffered words with no memory write in the reset cycle; in_ready=1 in the first cycle after rst falls.

Verification
REQ-038 Scenario, basic encodes with wr_ready=1, sent as addi x1,x0,5; sub x3,x1,x2; sw x2,8(x1) -> wr_data 0x00500093, 0x402081B3, 0x0020A423 at addresses 0x00, 0x04, 0x08, each one cycle after acceptance.
REQ-039 Scenario, control flow, sent as beq x1,x2,-4; jal x1,8; lui x5,0x12345000 -> 0xFE208EE3, 0x008000EF, 0x123452B7.
REQ-040 Scenario, backpressure: wr_ready=0 and in_valid held high with 5 requests -> 4 accepted, in_ready=0 afterwards; raising wr_ready drains all 4 in order, then the 5th is accepted.
REQ-041 Scenario, illegal request: addi with imm=0x800, or beq with imm=3 -> handshake completes, no wr_valid, err=1 and remains 1.
REQ-042 Scenario, wrap: BASE_ADDR=0xF8 with 3 writes -> addresses 0xF8, 0xFC, 0x00; words_written=3.
REQ-043 Scenario, reset mid-stream: 3 words buffered, rst pulsed for 1 cycle -> wr_valid=0, wr_addr=BASE_ADDR, words_written=0, and nothing is written.
